pid_output_stage: RTL and testbench
===================================

Name: pid_output_stage

Overview:
- Sits directly downstream of the PID block. Consumes the 14-bit PID output and produces the DAC word.
- Adds a programmable offset and clamps the result to programmable rails. The rail flags feed back to the PID anti-windup input.
- Contains a relock state machine. On lock loss it resets the PID integrator and drives a triangle search sweep until lock is reacquired.

Parameters:
- CNT_BITS, 16, width of the lock-loss delay counter and the sweep prescaler.
- STEP_BITS, 10, width of the sweep step size.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; one clock, reset is asynchronous and active-low.
- dat_i  in  14  signed PID output.
- mon_i  in  14  signed lock monitor signal, e.g. transmission.
- set_offset_i  in  14  signed output offset.
- set_lim_lo_i  in  14  signed lower rail.
- set_lim_hi_i  in  14  signed upper rail.
- relock_en_i  in  1  enables the relock FSM.
- set_thr_i  in  14  signed lock threshold on mon_i.
- set_delay_i  in  CNT_BITS  number of consecutive low cycles that declares lock loss.
- set_div_i  in  CNT_BITS  sweep prescaler; one tick every set_div_i+1 cycles.
- set_step_i  in  STEP_BITS  unsigned sweep increment per tick.
- dat_o  out  14  signed DAC word.
- railed_o  out  2  [0] at lower rail, [1] at upper rail; goes to the PID railed input.
- int_rst_o  out  1  PID integrator reset.
- state_o  out  2  FSM state, for readback.

Behaviour:
- Reset values: dat_o=0, railed_o=0, int_rst_o=0, state_o=OFF (0). All internal registers are 0.
- Output datapath, stage 1 (registered):
  - sum = dat_i + set_offset_i, held at 15 bits signed, so there is no overflow.
- Output datapath, stage 2 (registered):
  - sum <= lim_lo: output lim_lo, railed_o[0]=1.
  - sum >= lim_hi: output lim_hi, railed_o[1]=1.
  - Otherwise output sum[13:0] and railed_o=0.
  - When both conditions hold, set_lim_lo_i wins.
  - When set_lim_lo_i > set_lim_hi_i (misconfigured): output lim_lo, railed_o=2'b11.
  - Latency from dat_i to dat_o is 2 cycles.
- FSM states: OFF=0, LOCKED=1, LOSS_WAIT=2, SWEEP=3.
- Global FSM rule: relock_en_i=0 moves any state to OFF on the next edge. The loss counter and sweep registers are cleared.
- OFF:
  - Transparent datapath, int_rst_o=0.
  - Goes to LOCKED when relock_en_i=1.
- LOCKED:
  - Goes to LOSS_WAIT when mon_i < set_thr_i. The loss counter loads 1.
- LOSS_WAIT:
  - While mon_i < set_thr_i, the counter increments.
  - When the counter equals set_delay_i, go to SWEEP.
  - If mon_i >= set_thr_i, go back to LOCKED and clear the counter.
  - set_delay_i=0 or 1 means SWEEP on the first cycle after entry.
- SWEEP, entry:
  - The sweep register loads the current clamped dat_o. Direction is up.
- SWEEP, outputs:
  - int_rst_o=1 and railed_o=0.
  - dat_o comes from the sweep register through the same clamp stage, so latency stays 2 cycles.
- SWEEP, stepping:
  - Each prescaler tick adds or subtracts set_step_i in 15-bit arithmetic.
  - If the result crosses a rail, the register saturates at that rail and the direction reverses. It never wraps.
  - set_step_i=0 holds the output constant.
- SWEEP, exit:
  - mon_i >= set_thr_i returns the FSM to LOCKED on the next edge.
  - int_rst_o deasserts on the same edge.
  - The datapath switches back to the PID sum.
  - The prescaler clears on exit.
- int_rst_o is a registered output, asserted exactly while state is SWEEP.
- Async reset mid-sweep: all outputs are forced to their reset values immediately.

Optional Feature:
- Macro: PID_OUT_SLEW_LIMIT_EN.
- When defined:
  - An extra input set_slew_i (14-bit unsigned) is added.
  - Stage 2 limits |dat_o(n) - dat_o(n-1)| to set_slew_i, applied after clamping.
  - railed_o still reflects the clamp comparison, not the slew limit.
  - set_slew_i=0 disables the limit.
- When not defined:
  - The port is absent and there is no slew logic.
  - Behaviour is exactly as above.

Test Plan:
- Rails off, offset=100, lim=[-8192,8191]: dat_i=1000 → dat_o=1100 two cycles later, railed_o=00.
- Clamp: lim=[-500,500], offset=0:
  - dat_i=800 → dat_o=500, railed_o=10.
  - dat_i=-8192 → dat_o=-500, railed_o=01.
  - lim_lo=600, lim_hi=500 → dat_o=600, railed_o=11.
- Lock loss: relock_en=1, thr=1000, delay=5, mon_i drops to 0:
  - SWEEP entered after 5 low cycles, int_rst_o=1.
  - A 3-cycle low glitch instead returns the FSM to LOCKED.
- Sweep: div=3, step=100, lim=[-300,300], start 0:
  - dat_o steps 0,100,200,300,200,… every 4 cycles.
  - It never exceeds 300 and never wraps.
- Reacquire mid-sweep: mon_i=2000 → state LOCKED next edge, int_rst_o=0, dat_o follows dat_i+offset.
- Disable and reset:
  - relock_en_i=0 during SWEEP → OFF next cycle.
  - rstn_i low mid-sweep → dat_o=0, int_rst_o=0 asynchronously.

Source files
------------

// File: rtl/pid_output_stage.sv
// rtl/pid_output_stage.sv - PID output offset/clamp stage with relock sweep FSM.
// Optional slew limiter on the DAC word is built when PID_OUT_SLEW_LIMIT_EN is defined.
module pid_output_stage #(
   parameter int CNT_BITS  = 16,
   parameter int STEP_BITS = 10
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [13:0]          dat_i,
   input  logic [13:0]          mon_i,
   input  logic [13:0]          set_offset_i,
   input  logic [13:0]          set_lim_lo_i,
   input  logic [13:0]          set_lim_hi_i,
   input  logic                 relock_en_i,
   input  logic [13:0]          set_thr_i,
   input  logic [CNT_BITS-1:0]  set_delay_i,
   input  logic [CNT_BITS-1:0]  set_div_i,
   input  logic [STEP_BITS-1:0] set_step_i,
`ifdef PID_OUT_SLEW_LIMIT_EN
   input  logic [13:0]          set_slew_i,
`endif
   output logic [13:0]          dat_o,
   output logic [1:0]           railed_o,
   output logic                 int_rst_o,
   output logic [1:0]           state_o
);

   typedef enum logic [1:0] {
      OFF       = 2'd0,
      LOCKED    = 2'd1,
      LOSS_WAIT = 2'd2,
      SWEEP     = 2'd3
   } state_t;

   state_t               state;
   logic [CNT_BITS-1:0]  loss_cnt;
   logic [CNT_BITS-1:0]  presc;
   logic signed [14:0]   sweep;
   logic                 dir_up;

   logic signed [14:0]   s1;
   logic                 s1_sweep;

   logic signed [14:0]   pid_sum;
   logic signed [14:0]   lo;
   logic signed [14:0]   hi;
   logic signed [15:0]   step_s;
   logic signed [15:0]   up_nxt;
   logic signed [15:0]   dn_nxt;
   logic                 mon_low;
   logic signed [14:0]   clamp_v;
   logic [1:0]           rail_v;
   logic signed [15:0]   out_v;

   assign pid_sum = $signed({dat_i[13], dat_i}) + $signed({set_offset_i[13], set_offset_i});
   assign lo      = $signed({set_lim_lo_i[13], set_lim_lo_i});
   assign hi      = $signed({set_lim_hi_i[13], set_lim_hi_i});
   assign step_s  = $signed({{(16-STEP_BITS){1'b0}}, set_step_i});
   assign up_nxt  = $signed({sweep[14], sweep}) + step_s;
   assign dn_nxt  = $signed({sweep[14], sweep}) - step_s;
   assign mon_low = $signed(mon_i) < $signed(set_thr_i);
   assign state_o = state;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state     <= OFF;
         loss_cnt  <= '0;
         presc     <= '0;
         sweep     <= '0;
         dir_up    <= 1'b0;
         int_rst_o <= 1'b0;
      end else if (!relock_en_i) begin
         state     <= OFF;
         loss_cnt  <= '0;
         presc     <= '0;
         sweep     <= '0;
         dir_up    <= 1'b0;
         int_rst_o <= 1'b0;
      end else begin
         case (state)
            OFF: begin
               state <= LOCKED;
            end
            LOCKED: begin
               if (mon_low) begin
                  state    <= LOSS_WAIT;
                  loss_cnt <= {{(CNT_BITS-1){1'b0}}, 1'b1};
               end
            end
            LOSS_WAIT: begin
               if (!mon_low) begin
                  state    <= LOCKED;
                  loss_cnt <= '0;
               end else if (loss_cnt >= set_delay_i) begin
                  // Sweep resumes from whatever the DAC is showing, so the handover is bumpless.
                  state     <= SWEEP;
                  loss_cnt  <= '0;
                  presc     <= '0;
                  sweep     <= $signed({dat_o[13], dat_o});
                  dir_up    <= 1'b1;
                  int_rst_o <= 1'b1;
               end else begin
                  loss_cnt <= loss_cnt + 1'b1;
               end
            end
            SWEEP: begin
               if (!mon_low) begin
                  state     <= LOCKED;
                  presc     <= '0;
                  int_rst_o <= 1'b0;
               end else if (presc == set_div_i) begin
                  presc <= '0;
                  if (dir_up) begin
                     if (up_nxt >= $signed({hi[14], hi})) begin
                        sweep  <= hi;
                        dir_up <= 1'b0;
                     end else begin
                        sweep  <= up_nxt[14:0];
                     end
                  end else begin
                     if (dn_nxt <= $signed({lo[14], lo})) begin
                        sweep  <= lo;
                        dir_up <= 1'b1;
                     end else begin
                        sweep  <= dn_nxt[14:0];
                     end
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            default: state <= OFF;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         s1       <= '0;
         s1_sweep <= 1'b0;
      end else if (state == SWEEP) begin
         s1       <= sweep;
         s1_sweep <= 1'b1;
      end else begin
         s1       <= pid_sum;
         s1_sweep <= 1'b0;
      end
   end

   // Inverted rails are treated as a fault: park on the lower rail and flag both.
   always_comb begin
      clamp_v = s1;
      rail_v  = 2'b00;
      if (lo > hi) begin
         clamp_v = lo;
         rail_v  = 2'b11;
      end else if (s1 <= lo) begin
         clamp_v = lo;
         rail_v  = 2'b01;
      end else if (s1 >= hi) begin
         clamp_v = hi;
         rail_v  = 2'b10;
      end
   end

`ifdef PID_OUT_SLEW_LIMIT_EN
   logic signed [15:0] prev_s;
   logic signed [15:0] slew_s;
   logic signed [15:0] delta;

   assign prev_s = $signed({{2{dat_o[13]}}, dat_o});
   assign slew_s = $signed({2'b00, set_slew_i});
   assign delta  = $signed({clamp_v[14], clamp_v}) - prev_s;

   always_comb begin
      out_v = $signed({clamp_v[14], clamp_v});
      if (set_slew_i != 14'd0) begin
         if (delta > slew_s) begin
            out_v = prev_s + slew_s;
         end else if (delta < -slew_s) begin
            out_v = prev_s - slew_s;
         end
      end
   end
`else
   assign out_v = $signed({clamp_v[14], clamp_v});
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         dat_o    <= '0;
         railed_o <= 2'b00;
      end else begin
         dat_o    <= out_v[13:0];
         railed_o <= s1_sweep ? 2'b00 : rail_v;
      end
   end

endmodule

// File: tb/tb_pid_output_stage.sv
// tb/tb_pid_output_stage.sv - directed scoreboard bench for pid_output_stage.
module tb_pid_output_stage;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [13:0] dat = '0;
   logic [13:0] mon = '0;
   logic [13:0] offset = '0;
   logic [13:0] lim_lo = 14'h2000;
   logic [13:0] lim_hi = 14'h1fff;
   logic        relock_en = 1'b0;
   logic [13:0] thr = '0;
   logic [15:0] delay = '0;
   logic [15:0] div = '0;
   logic [9:0]  step = '0;
   logic [13:0] dat_o;
   logic [1:0]  railed;
   logic        int_rst;
   logic [1:0]  state;

   int n_checks = 0;
   int n_fail = 0;
   int exp_q[$];
   int rail_q[$];

   pid_output_stage #(.CNT_BITS(16), .STEP_BITS(10)) dut (
      .clk_i(clk), .rstn_i(rstn), .dat_i(dat), .mon_i(mon),
      .set_offset_i(offset), .set_lim_lo_i(lim_lo), .set_lim_hi_i(lim_hi),
      .relock_en_i(relock_en), .set_thr_i(thr), .set_delay_i(delay),
      .set_div_i(div), .set_step_i(step),
`ifdef PID_OUT_SLEW_LIMIT_EN
      .set_slew_i(14'd0),
`endif
      .dat_o(dat_o), .railed_o(railed), .int_rst_o(int_rst), .state_o(state)
   );

   always #5 clk = ~clk;

   function automatic int sd();
      return int'($signed(dat_o));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply(input string tag, input int d, input int off, input int lo, input int hi,
                        input int exp_d, input int exp_r);
      dat = 14'(d); offset = 14'(off); lim_lo = 14'(lo); lim_hi = 14'(hi);
      exp_q.push_back(exp_d);
      rail_q.push_back(exp_r);
      tick();
      tick();
      check({tag, "_dat"}, sd(), exp_q.pop_front());
      check({tag, "_rail"}, int'(railed), rail_q.pop_front());
   endtask

   task automatic wait_state(input string tag, input int s, input int budget);
      int found = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (int'(state) == s) begin
            found = 1;
            break;
         end
      end
      check(tag, found, 1);
   endtask

   initial begin
      int prev, last_change, seen, changes;
      #12;
      check("reset_dat", sd(), 0);
      check("reset_rail", int'(railed), 0);
      check("reset_int_rst", int'(int_rst), 0);
      check("reset_state", int'(state), 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      tick();

      // Latency: one edge after a new input the old word is still shown.
      dat = 14'd1000; offset = 14'd100;
      exp_q.push_back(1100); rail_q.push_back(0);
      tick();
      check("latency1_dat", sd(), 0);
      tick();
      check("offset_dat", sd(), exp_q.pop_front());
      check("offset_rail", int'(railed), rail_q.pop_front());

      apply("clamp_hi", 800, 0, -500, 500, 500, 2);
      apply("clamp_lo", -8192, 0, -500, 500, -500, 1);
      apply("at_hi", 500, 0, -500, 500, 500, 2);
      apply("at_lo", -500, 0, -500, 500, -500, 1);
      apply("inside", -123, 0, -500, 500, -123, 0);
      apply("misconf", 0, 0, 600, 500, 600, 3);
      apply("neg_off", 8191, -8192, -8192, 8191, -1, 0);

      // Lock loss after delay=5.
      apply("zero", 0, 0, -8192, 8191, 0, 0);
      thr = 14'd1000; delay = 16'd5; mon = 14'd2000; relock_en = 1'b1;
      tick();
      check("off_to_locked", int'(state), 1);
      mon = 14'd0;
      repeat (4) tick();
      check("loss_wait", int'(state), 2);
      check("no_int_rst_yet", int'(int_rst), 0);
      repeat (2) tick();
      check("sweep_entered", int'(state), 3);
      check("sweep_int_rst", int'(int_rst), 1);

      // Short glitch must not trigger a sweep.
      mon = 14'd2000;
      tick();
      check("back_locked", int'(state), 1);
      check("int_rst_cleared", int'(int_rst), 0);
      mon = 14'd0;
      repeat (3) tick();
      mon = 14'd2000;
      tick();
      check("glitch_locked", int'(state), 1);
      repeat (5) tick();
      check("glitch_stays", int'(state), 1);

      // Triangle sweep between +-300.
      lim_lo = -14'sd300; lim_hi = 14'sd300; div = 16'd3; step = 10'd100; delay = 16'd1;
      tick(); tick();
      check("sweep_start_dat", sd(), 0);
      foreach (exp_q[i]) exp_q.delete(i);
      for (int v = 100; v <= 300; v += 100) exp_q.push_back(v);
      for (int v = 200; v >= -300; v -= 100) exp_q.push_back(v);
      exp_q.push_back(-200);
      exp_q.push_back(-100);
      mon = 14'd0;
      wait_state("sweep2_entered", 3, 10);
      prev = sd();
      last_change = 0;
      changes = 0;
      for (int c = 1; c <= 300 && exp_q.size() > 0; c++) begin
         tick();
         if (sd() != prev) begin
            check("sweep_step", sd(), exp_q.pop_front());
            seen = (sd() <= 300 && sd() >= -300) ? 1 : 0;
            check("sweep_bound", seen, 1);
            if (changes > 0) check("sweep_period", c - last_change, 4);
            changes++;
            last_change = c;
            prev = sd();
         end
      end
      check("sweep_done", exp_q.size(), 0);
      check("sweep_rail_zero", int'(railed), 0);
      check("sweep_int_rst2", int'(int_rst), 1);

      // Reacquire mid-sweep.
      dat = 14'd50; offset = 14'd0;
      mon = 14'd2000;
      tick();
      check("reacq_state", int'(state), 1);
      check("reacq_int_rst", int'(int_rst), 0);
      tick(); tick();
      check("reacq_dat", sd(), 50);

      // Disable during sweep.
      mon = 14'd0;
      wait_state("sweep3_entered", 3, 10);
      relock_en = 1'b0;
      tick();
      check("disable_state", int'(state), 0);
      check("disable_int_rst", int'(int_rst), 0);

      // Async reset mid-sweep.
      relock_en = 1'b1;
      wait_state("sweep4_entered", 3, 10);
      repeat (3) tick();
      check("pre_reset_dat", sd(), 50);
      rstn = 1'b0;
      #2;
      check("areset_dat", sd(), 0);
      check("areset_int_rst", int'(int_rst), 0);
      check("areset_state", int'(state), 0);
      check("areset_rail", int'(railed), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
